// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receives 8N1 UART bytes from an asynchronous line. Each good byte is pushed
// into a small circular FIFO and offered to a consumer over valid/ready.
//
// Handshake: a byte transfers on every rising clk edge where data_valid_out
// and data_ready_in are both high. data_out holds the FIFO head and stays
// stable while data_valid_out is high and the head has not been popped.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   rx             in   asynchronous UART line, idle high
//   data_out       out  [7:0] byte at the FIFO head (0 while empty)
//   data_valid_out out  FIFO non-empty
//   data_ready_in  in   consumer accepts the head byte
//   frame_err      out  one-cycle pulse on a bad stop bit
//   overflow       out  sticky; a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    input  logic       data_ready_in,
    output logic       frame_err,
    output logic       overflow
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle line level
    // ------------------------------------------------------------------
    logic sync1;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // The stop bit is sampled on this edge; a high line completes the byte.
    logic stop_sample;
    logic push;

    assign stop_sample = (state == S_STOP) && (cnt == CNT_LAST);
    assign push        = stop_sample && rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        if (rxs) begin
                            // Too short to be a start bit
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        // LSB arrives first, so shift right into bit 7
                        shreg   <= {rxs, shreg[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_RECOVER;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RECOVER: begin
                    // Hold off until the line returns high so a break
                    // condition cannot start a phantom frame.
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (count == CNT_FULL);
    assign pop     = data_valid_out && data_ready_in;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop);

    // Storage is not reset; data_out masks it while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign data_valid_out = (count != '0);
    assign data_out       = data_valid_out ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial command receiver for the tiniest-GPU core. It samples the asynchronous UART line (`rx`, driven from `ui_in[3]` at top level) in the GPU's 20 MHz domain and deframes 8N1 bytes. Received bytes go into a small FIFO and are presented to the GPU's command decoder through a valid/ready handshake. Framing errors and FIFO overflows are flagged for debug visibility on spare pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 174: clock cycles per UART bit (20 MHz / 115200 ≈ 173.6). Legal range ≥ 4.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock (`clk_20` at top level). All logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `rx`  in  1: asynchronous UART line, idle high.
- `data_out`  out  8: byte at FIFO head.
- `data_valid_out`  out  1: FIFO non-empty.
- `data_ready_in`  in  1: consumer accepts the head byte.
- `frame_err`  out  1: one-cycle pulse when a bad stop bit is detected.
- `overflow`  out  1: sticky; set when a byte is dropped because the FIFO is full.

## Operation
- **Input sync:** 2-flop synchronizer on `rx`. Both flops reset to 1. `rxs` is the second flop.
- **Receiver FSM:** states IDLE, START, DATA, STOP, RECOVER. Bit counter 0..CLKS_PER_BIT-1. Bit index 0..7. 8-bit shift register.
  - IDLE: if `rxs`==0, go to START and clear the counter.
  - START: when counter == (CLKS_PER_BIT-1)/2 (integer divide), sample `rxs`.
    - If 1: glitch, return to IDLE with no flags.
    - If 0: go to DATA with counter and bit index cleared.
  - DATA: when counter == CLKS_PER_BIT-1, sample `rxs` into the shift register, LSB first (shift right, new bit into bit 7), and clear the counter.
    - After bit index 7 is sampled, go to STOP.
  - STOP: when counter == CLKS_PER_BIT-1, sample `rxs`.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to RECOVER.
  - RECOVER: wait for `rxs`==1, then go to IDLE. This prevents a stuck-low or break line from retriggering.
- **FIFO:** circular buffer with read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
  - Push: on a valid stop bit.
  - Pop: on `data_valid_out && data_ready_in`.
  - Push while full with no pop: byte dropped, `overflow` set. `overflow` clears only on reset.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: not possible, since `data_valid_out` is 0.
- **Output:** `data_out` is registered memory at the read pointer, so it reflects the head combinationally from pointer state. `data_valid_out` = (count != 0). Once valid is high, `data_out` stays stable until it is popped.

## Timing
- **Reset** (`rst_n`==0 at a clock edge):
  - FSM to IDLE; counters, pointers and count cleared.
  - `data_valid_out`=0, `frame_err`=0, `overflow`=0, `data_out`=0 (FIFO storage need not be cleared; `data_out` is forced to 0 while empty).
  - Reset mid-frame aborts the frame, and the partial byte is never pushed.
- **Sample points** (cycles after `rxs` first reads 0 in IDLE):
  - Start check: (CLKS_PER_BIT-1)/2 + 1.
  - Each data bit: one further CLKS_PER_BIT later.
  - Stop bit: one further CLKS_PER_BIT after data bit 7.
- **Latency:** `data_valid_out` rises on the cycle after the stop-bit sample edge. Add 2 cycles for the synchronizer, measured from the `rx` line.
- **Back-to-back frames:** a start edge arriving immediately after the stop sample is detected from IDLE on the next cycle. No idle gap is required beyond the stop-bit half.
- **Handshake:** one byte transfers per cycle while valid&&ready. Pop and push in the same cycle are independent.

## Test plan
Run with `CLKS_PER_BIT`=8, `FIFO_DEPTH`=4, `data_ready_in`=1 unless stated.
- **Single byte:** send frame 0xA5 → exactly one valid cycle with `data_out`=0xA5; `frame_err`=0, `overflow`=0.
- **Start glitch:** drive `rx` low for 2 cycles, then high → FSM returns to IDLE, no push, no `frame_err`.
- **Bad stop bit:** send 0x3C with stop bit 0, keep `rx` low 30 cycles, then send 0x11 → one `frame_err` pulse, 0x3C not delivered, only 0x11 delivered.
- **Overflow:** hold `data_ready_in`=0 and send 0x01..0x05 → FIFO holds 0x01..0x04 and `overflow` becomes 1 after frame 5. Release ready → 0x01, 0x02, 0x03, 0x04 delivered in order, one per cycle; `overflow` stays 1.
- **Full simultaneous push/pop:** fill with 4 bytes, then assert ready for exactly the cycle of the 5th push (0x55) → no overflow, and 0x55 is delivered last.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during data bit 4 of 0xFF → all outputs 0; the next full frame 0x42 is received correctly.
